// File: rtl/decode_pipe.sv
// decode_pipe: registered, handshaked instruction decoder feeding ctrl_unit.
// Tracks one outstanding command (proc / rdn load / dnn load), stalls fetch on
// conflicts, flags illegal opcodes and counts accepted instructions.
// Optional feature macro: DECODE_ERR_HALT_EN -- an illegal opcode parks the
// decoder in HALT (instr_ready low) until err_clr.
module decode_pipe #(
    parameter  int INSTR_W  = 32,
    parameter  int OPC_W    = 3,
    parameter  int NUM_REGS = 3,
    parameter  int CNT_W    = 16,
    localparam int DATA_W   = INSTR_W - OPC_W - 1,
    localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               reg_wr_en,
    output logic [SEL_W-1:0]   reg_sel,
    output logic [DATA_W-1:0]  reg_data,
    output logic               begin_proc,
    output logic               begin_rdn_load,
    output logic               begin_dnn_load,
    input  logic               cmd_done,
    output logic               busy,
    output logic               illegal_err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   instr_cnt
);
    localparam int B = 2 ** (OPC_W - 1);
    localparam logic [OPC_W-1:0] OP_RDN = OPC_W'(B);
    localparam logic [OPC_W-1:0] OP_DNN = OPC_W'(B + 1);
    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(B + 2);
    localparam logic [OPC_W-1:0] NREG   = OPC_W'(NUM_REGS);

    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

    typedef struct packed {
        logic reg_wr;
        logic proc;
        logic rdn;
        logic dnn;
        logic nop;
        logic cmd;
        logic ill;
    } dec_t;

    state_t           state;
    dec_t             dec;
    logic [OPC_W-1:0] opc;
    logic             sync;
    logic             accept;
    logic             busy_nxt;

    assign opc  = instr[INSTR_W-2 -: OPC_W];
    assign sync = instr[INSTR_W-1];

    // Opcode classification of the presented instruction
    always_comb begin
        dec        = '0;
        dec.reg_wr = opc < NREG;
        dec.proc   = opc == '0;
        dec.rdn    = opc == OP_RDN;
        dec.dnn    = opc == OP_DNN;
        dec.nop    = opc == OP_NOP;
        dec.cmd    = dec.proc | dec.rdn | dec.dnn;
        dec.ill    = ~(dec.reg_wr | dec.rdn | dec.dnn | dec.nop);
    end

    // Stall on HALT, or while busy for another command or a SYNC-marked instr
    assign instr_ready = rst_n && (state != HALT) && !(busy && (dec.cmd || sync));
    assign accept      = instr_valid && instr_ready;
    // A new command accept wins over a same-cycle cmd_done
    assign busy_nxt    = (accept && dec.cmd) || (busy && !cmd_done);

    // Registered decode outputs, busy/error tracking, counter and FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_en      <= 1'b0;
            reg_sel        <= '0;
            reg_data       <= '0;
            begin_proc     <= 1'b0;
            begin_rdn_load <= 1'b0;
            begin_dnn_load <= 1'b0;
            busy           <= 1'b0;
            illegal_err    <= 1'b0;
            instr_cnt      <= '0;
            state          <= RUN;
        end else begin
            reg_wr_en      <= accept && dec.reg_wr;
            begin_proc     <= accept && dec.proc;
            begin_rdn_load <= accept && dec.rdn;
            begin_dnn_load <= accept && dec.dnn;
            if (accept && dec.reg_wr) begin
                reg_sel  <= opc[SEL_W-1:0];
                reg_data <= instr[DATA_W-1:0];
            end
            busy <= busy_nxt;
            if (accept && dec.ill)
                illegal_err <= 1'b1;
            else if (err_clr)
                illegal_err <= 1'b0;
            if (accept && instr_cnt != {CNT_W{1'b1}})
                instr_cnt <= instr_cnt + 1'b1;
            case (state)
                RUN, WAIT: begin
`ifdef DECODE_ERR_HALT_EN
                    if (accept && dec.ill)
                        state <= HALT;
                    else
`endif
                        state <= busy_nxt ? WAIT : RUN;
                end
                HALT: if (err_clr) state <= busy_nxt ? WAIT : RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule
